// File: rtl/rf_wr_arbiter_pkg.sv
// Shared widths, requester indices and helpers for the register-file write arbiter.
// A write to address 0 is accepted but never reaches the register file.
package rf_wr_arbiter_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int DATA_W    = 32;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_MDU  = 1'b1;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]    data;
  } wr_req_t;

  // Register 0 is hard-wired, so a transfer to it must not raise the write enable.
  function automatic logic writes_rf(input logic [RF_ADDR_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/rf_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester other than the pointer wins.
// Purely combinational; stall suppresses every grant.
module rr_arb2
  import rf_wr_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       stall,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (!stall) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (pointer == REQ_CORE) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Arbitrates core writeback and the multi-cycle unit onto the single register-file
// write port; ready is combinational, the write port is a one-cycle registered stage.
module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter bit PRIO0_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 req0_valid,
  input  logic [RF_ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [RF_ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  output logic                 we3,
  output logic [RF_ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0]    wd3,
  output logic                 last_grant
);

  // Pointing at the MDU after reset hands the first contention to the core.
  localparam logic RST_LAST = PRIO0_FIRST ? REQ_MDU : REQ_CORE;

  logic [1:0] grant_p0;
  logic       vld_p0;
  wr_req_t    sel_p0;

  logic                 vld_p1;
  logic [RF_ADDR_W-1:0] wa_p1;
  logic [DATA_W-1:0]    wd_p1;

  // Stage p0: arbitration and request select
  rr_arb2 u_rr_arb2 (
    .valid   ({req1_valid, req0_valid}),
    .stall   (stall | reset),
    .pointer (last_grant),
    .grant   (grant_p0)
  );

  assign req0_ready = grant_p0[0];
  assign req1_ready = grant_p0[1];
  assign vld_p0     = |grant_p0;

  always_comb begin
    sel_p0 = '{addr: req0_addr, data: req0_data};
    if (grant_p0[1]) begin
      sel_p0 = '{addr: req1_addr, data: req1_data};
    end
  end

  // Stage p1: registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= RST_LAST;
      vld_p1     <= 1'b0;
      wa_p1      <= '0;
      wd_p1      <= '0;
    end else begin
      if (vld_p0) begin
        last_grant <= grant_p0[1];
      end
      vld_p1 <= vld_p0 && writes_rf(sel_p0.addr);
      if (vld_p0 && writes_rf(sel_p0.addr)) begin
        wa_p1 <= sel_p0.addr;
        wd_p1 <= sel_p0.data;
      end
    end
  end

  assign we3 = vld_p1;
  assign wa3 = wa_p1;
  assign wd3 = wd_p1;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: a behavioural model predicts grants and the
// next-cycle write port; a monitor pops the prediction after every rising edge.
module tb_rf_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_addr = '0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_addr = '0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        last_grant;

  rf_wr_arbiter #(.PRIO0_FIRST(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .we3        (we3),
    .wa3        (wa3),
    .wd3        (wd3),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        lg;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int wr_lo = 0;
  int wr_hi = 0;

  // Model state: who was granted last, and what the write port currently shows.
  logic        m_last = 1'b1;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; returns the requester the model says is accepted (-1 none).
  task automatic cycle(input logic rst, input logic st,
                       input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       output int g);
    exp_t e;
    @(negedge clk);
    reset = rst; stall = st;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    g = -1;
    if (!rst && !st) begin
      if (v0 && v1) g = (m_last == 1'b0) ? 1 : 0;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    #1;
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
    e.we = 1'b0;
    if (rst) begin
      m_last = 1'b1; m_wa = '0; m_wd = '0;
    end else if (g >= 0) begin
      m_last = (g == 1);
      if ((g == 0 ? a0 : a1) != 5'd0) begin
        e.we = 1'b1;
        m_wa = (g == 0) ? a0 : a1;
        m_wd = (g == 0) ? d0 : d1;
      end
    end
    e.wa = m_wa; e.wd = m_wd; e.lg = m_last;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (we3 === 1'b1) begin
        if (wa3 < 5'd16) wr_lo++;
        else wr_hi++;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("we3", {31'd0, we3}, {31'd0, e.we});
        chk("wa3", {27'd0, wa3}, {27'd0, e.wa});
        chk("wd3", wd3, e.wd);
        chk("last_grant", {31'd0, last_grant}, {31'd0, e.lg});
      end
    end
  end

  initial begin : stimulus
    int g;
    logic        v0, v1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    int lo0, hi0;

    cycle(1, 0, 0, 0, 0, 0, 0, 0, g);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, g);
    // Single requester
    cycle(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, g);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, g);
    // Contention right after reset: core first, then MDU
    cycle(1, 0, 0, 0, 0, 0, 0, 0, g);
    cycle(0, 0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, g);
    cycle(0, 0, 0, 0, 0, 1, 5'd4, 32'h22, g);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, g);
    // Register 0 write is accepted but suppressed
    cycle(0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, g);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, g);
    // Stall with both valid, then release
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 5'd7, 32'hA7, 1, 5'd8, 32'hB8, g);
    cycle(0, 0, 1, 5'd7, 32'hA7, 1, 5'd8, 32'hB8, g);
    cycle(0, 0, 1, 5'd7, 32'hA7, 1, 5'd8, 32'hB8, g);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, g);
    // Reset coincident with a core transfer
    cycle(1, 0, 1, 5'd9, 32'hC0FFEE, 0, 0, 0, g);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, g);

    // Sustained traffic: both continuously valid for 8 cycles
    v0 = 1; a0 = 5'd1;  d0 = $urandom;
    v1 = 1; a1 = 5'd16; d1 = $urandom;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, g);
    lo0 = wr_lo; hi0 = wr_hi;
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, v0, a0, d0, v1, a1, d1, g);
      if (g == 0) begin a0 = a0 + 5'd1; d0 = $urandom; end
      if (g == 1) begin a1 = a1 + 5'd1; d1 = $urandom; end
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, g);
    chk("sustained_core_writes", wr_lo - lo0, 4);
    chk("sustained_mdu_writes", wr_hi - hi0, 4);

    // Randomised traffic, requests held until accepted
    v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < 500; i++) begin
      if (!v0 && ($urandom % 3 == 0)) begin
        v0 = 1; a0 = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom); d0 = $urandom;
      end
      if (!v1 && ($urandom % 3 == 0)) begin
        v1 = 1; a1 = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom); d1 = $urandom;
      end
      cycle(($urandom % 64) == 0, ($urandom % 8) == 0, v0, a0, d0, v1, a1, d1, g);
      if (g == 0) v0 = 0;
      if (g == 1) v1 = 0;
    end

    cycle(0, 0, 0, 0, 0, 0, 0, 0, g);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
